// File: rtl/simple_dma_rd_pkg.sv
// Shared DMA package: default bus widths, read-DMA FSM encoding and the
// buffer descriptor layout {size, addr}. The write DMA uses the same layout.
package simple_dma_rd_pkg;

  localparam int DMA_ADR_W  = 28;
  localparam int DMA_DATA_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_ISSUE,
    ST_DRAIN
  } dma_state_e;

  // Size occupies the upper ADR_W bits of a command FIFO word.
  typedef struct packed {
    logic [DMA_ADR_W-1:0] size;
    logic [DMA_ADR_W-1:0] addr;
  } dma_desc_t;

endpackage

// File: rtl/fifo_bram_sync.sv
// Synchronous FIFO with a registered (block-RAM style) read port.
// DOUT updates one cycle after an accepted RD and holds until the next one.
// Writes to a full FIFO and reads from an empty FIFO are ignored.
// Ports: CLK, SRST (sync, active-high), DIN/WR write side, DOUT/RD read side,
// FULL/EMPTY plus AFULL/AEMPTY thresholds set by the offset parameters.
module fifo_bram_sync #(
  parameter int DATA_WIDTH    = 56,
  parameter int DEPTH         = 3,
  parameter int AFULL_OFFSET  = 2,
  parameter int AEMPTY_OFFSET = 2
) (
  input  logic                  CLK,
  input  logic                  SRST,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  WR,
  output logic [DATA_WIDTH-1:0] DOUT,
  input  logic                  RD,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  AFULL,
  output logic                  AEMPTY
);

  localparam int N = 1 << DEPTH;
  localparam logic [DEPTH:0] LVL_FULL   = (DEPTH+1)'(N);
  localparam logic [DEPTH:0] LVL_AFULL  = (DEPTH+1)'(N - AFULL_OFFSET);
  localparam logic [DEPTH:0] LVL_AEMPTY = (DEPTH+1)'(AEMPTY_OFFSET);

  logic [DATA_WIDTH-1:0] mem [N];
  logic [DEPTH-1:0]      wp, rp;
  logic [DEPTH:0]        cnt;
  logic                  wr_ok, rd_ok;

  assign FULL   = (cnt == LVL_FULL);
  assign EMPTY  = (cnt == '0);
  assign AFULL  = (cnt >= LVL_AFULL);
  assign AEMPTY = (cnt <= LVL_AEMPTY);
  assign wr_ok  = WR & ~FULL;
  assign rd_ok  = RD & ~EMPTY;

  always_ff @(posedge CLK) begin
    if (SRST) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_ok) wp <= wp + DEPTH'(1);
      if (rd_ok) rp <= rp + DEPTH'(1);
      if (wr_ok && !rd_ok)      cnt <= cnt + (DEPTH+1)'(1);
      else if (rd_ok && !wr_ok) cnt <= cnt - (DEPTH+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wp] <= DIN;
    if (rd_ok) DOUT <= mem[rp];
  end

endmodule

// File: rtl/simple_dma_rd.sv
// Read DMA: descriptors {BUF_SIZE, START_ADR} are queued on START rising
// edges, then read from SDRAM with pipelined Avalon-MM reads and forwarded
// to the downstream data FIFO. DONE_CNT counts completed buffers.
// Ports: CLK/SRST; START_ADR, BUF_SIZE, START descriptor input; DONE_CNT,
// BUSY, CMD_FIFO_EMPTY/AEMPTY status; FIFO_DATA/FIFO_WR/FIFO_AFULL downstream;
// SDRAM_ADDRESS/READ/WAITREQUEST/READDATA/READDATAVALID memory read port.
module simple_dma_rd
  import simple_dma_rd_pkg::*;
#(
  parameter int ADR_W     = DMA_ADR_W,
  parameter int DATA_W    = DMA_DATA_W,
  parameter int MAX_OUTST = 8,
  parameter int CMD_DEPTH = 3
) (
  input  logic              CLK,
  input  logic              SRST,
  input  logic [ADR_W-1:0]  START_ADR,
  input  logic [ADR_W-1:0]  BUF_SIZE,
  input  logic              START,
  output logic [15:0]       DONE_CNT,
  output logic              BUSY,
  output logic              CMD_FIFO_EMPTY,
  output logic              CMD_FIFO_AEMPTY,
  output logic [DATA_W-1:0] FIFO_DATA,
  output logic              FIFO_WR,
  input  logic              FIFO_AFULL,
  output logic [ADR_W-1:0]  SDRAM_ADDRESS,
  output logic              SDRAM_READ,
  input  logic              SDRAM_WAITREQUEST,
  input  logic [DATA_W-1:0] SDRAM_READDATA,
  input  logic              SDRAM_READDATAVALID
);

  localparam int OW = $clog2(MAX_OUTST + 1);

  dma_state_e         state, state_nxt;
  logic               start_q, cmd_wr, cmd_rd, cmd_full;
  logic [2*ADR_W-1:0] cmd_dout;
  logic [ADR_W-1:0]   ld_addr, ld_size, rem, rem_base, rem_nxt;
  logic [OW-1:0]      out_cnt, out_nxt;
  logic               acc, ret, issue_ok, read_nxt, done_inc;

  assign cmd_wr             = START & ~start_q & ~cmd_full;
  assign {ld_size, ld_addr} = cmd_dout;
  assign BUSY               = (state != ST_IDLE);

  fifo_bram_sync #(
    .DATA_WIDTH   (2*ADR_W),
    .DEPTH        (CMD_DEPTH),
    .AFULL_OFFSET (2),
    .AEMPTY_OFFSET(2)
  ) u_cmd_fifo (
    .CLK   (CLK),
    .SRST  (SRST),
    .DIN   ({BUF_SIZE, START_ADR}),
    .WR    (cmd_wr),
    .DOUT  (cmd_dout),
    .RD    (cmd_rd),
    .FULL  (cmd_full),
    .EMPTY (CMD_FIFO_EMPTY),
    .AFULL (),
    .AEMPTY(CMD_FIFO_AEMPTY)
  );

  // Read strobe is registered, so FETCH spans the strobe cycle plus the
  // FIFO's read latency before LOAD samples DOUT.
  always_comb begin
    state_nxt = state;
    done_inc  = 1'b0;
    unique case (state)
      ST_IDLE:  if (!CMD_FIFO_EMPTY) state_nxt = ST_FETCH;
      ST_FETCH: if (!cmd_rd) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (ld_size == '0) begin
          done_inc  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: if (rem == '0) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (out_cnt == '0) begin
          done_inc  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request decision is made on next-cycle counts so a new read can follow
  // an acceptance back to back. A stalled request always holds.
  always_comb begin
    acc      = SDRAM_READ & ~SDRAM_WAITREQUEST;
    ret      = SDRAM_READDATAVALID & (out_cnt != '0);
    rem_base = (state == ST_LOAD) ? ld_size : rem;
    rem_nxt  = rem_base - ADR_W'(acc);
    out_nxt  = out_cnt + OW'(acc) - OW'(ret);
    issue_ok = ((state == ST_LOAD) || (state == ST_ISSUE)) && (rem_nxt != '0) &&
               (out_nxt < OW'(MAX_OUTST)) && !FIFO_AFULL;
    read_nxt = (SDRAM_READ & SDRAM_WAITREQUEST) | issue_ok;
  end

  always_ff @(posedge CLK) begin
    if (SRST) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (SRST) begin
      start_q    <= 1'b0;
      cmd_rd     <= 1'b0;
      SDRAM_READ <= 1'b0;
      rem        <= '0;
      out_cnt    <= '0;
      FIFO_WR    <= 1'b0;
      DONE_CNT   <= '0;
    end else begin
      start_q    <= START;
      cmd_rd     <= (state == ST_IDLE) & ~CMD_FIFO_EMPTY;
      SDRAM_READ <= read_nxt;
      rem        <= rem_nxt;
      out_cnt    <= out_nxt;
      FIFO_WR    <= ret;
      if (done_inc) DONE_CNT <= DONE_CNT + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (state == ST_LOAD) SDRAM_ADDRESS <= ld_addr;
    else if (acc)         SDRAM_ADDRESS <= SDRAM_ADDRESS + ADR_W'(1);
    FIFO_DATA <= SDRAM_READDATA;
  end

endmodule

// File: tb/tb_simple_dma_rd.sv
module tb_simple_dma_rd;

  localparam int MAXO = 8;

  logic         CLK = 1'b0;
  logic         SRST = 1'b1;
  logic [27:0]  START_ADR = '0, BUF_SIZE = '0;
  logic         START = 1'b0;
  logic [15:0]  DONE_CNT;
  logic         BUSY, CMD_FIFO_EMPTY, CMD_FIFO_AEMPTY;
  logic [127:0] FIFO_DATA;
  logic         FIFO_WR;
  logic         FIFO_AFULL = 1'b0;
  logic [27:0]  SDRAM_ADDRESS;
  logic         SDRAM_READ;
  logic         SDRAM_WAITREQUEST = 1'b0;
  logic [127:0] SDRAM_READDATA = '0;
  logic         SDRAM_READDATAVALID = 1'b0;

  simple_dma_rd dut (
    .CLK(CLK), .SRST(SRST), .START_ADR(START_ADR), .BUF_SIZE(BUF_SIZE),
    .START(START), .DONE_CNT(DONE_CNT), .BUSY(BUSY),
    .CMD_FIFO_EMPTY(CMD_FIFO_EMPTY), .CMD_FIFO_AEMPTY(CMD_FIFO_AEMPTY),
    .FIFO_DATA(FIFO_DATA), .FIFO_WR(FIFO_WR), .FIFO_AFULL(FIFO_AFULL),
    .SDRAM_ADDRESS(SDRAM_ADDRESS), .SDRAM_READ(SDRAM_READ),
    .SDRAM_WAITREQUEST(SDRAM_WAITREQUEST), .SDRAM_READDATA(SDRAM_READDATA),
    .SDRAM_READDATAVALID(SDRAM_READDATAVALID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [27:0] adr;
    logic [27:0] size;
    int          lat;
    int          wpct;
    int          afull_after;
    int          span;
    logic [15:0] exp_done;
  } vec_t;

  typedef struct {
    int          due;
    logic [27:0] a;
  } pend_t;

  int checks = 0, failures = 0;
  int cyc = 0, acc_cnt = 0, wr_cnt = 0;
  int lat = 3, wpct = 0, afull_after = 0, wr_base = 0, afull_t = 0, afull_wr = 0;
  int first_acc = -1, last_acc = -1, max_pend = 0, stall_at = 1 << 30;
  bit stall_all = 0, lim_chk_en = 1, afull_done = 0;
  bit prev_read = 0, prev_stall = 0, prev_afull = 0;
  logic [27:0] prev_adr = '0;
  logic [27:0] exp_adr[$], exp_wr[$];
  pend_t pend[$];

  function automatic logic [127:0] data_of(input logic [27:0] a);
    logic [31:0] x;
    x = {4'h0, a};
    return {x ^ 32'hDEAD0000, ~x, x + 32'h12345678, x[15:0], x[31:16]};
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // SDRAM slave model plus per-cycle protocol monitors, all on the falling edge.
  always @(negedge CLK) begin
    bit w;
    cyc++;
    if (FIFO_WR) begin
      wr_cnt++;
      if (FIFO_AFULL) afull_wr++;
      if (exp_wr.size() == 0) check("unexpected_fifo_wr", FIFO_WR, 0);
      else check("fifo_data", FIFO_DATA, data_of(exp_wr.pop_front()));
    end
    if (lim_chk_en) begin
      if (pend.size() > max_pend) max_pend = pend.size();
      if (pend.size() >= MAXO) check("read_low_at_max", SDRAM_READ, 0);
      if (prev_stall) begin
        check("hold_read", SDRAM_READ, 1);
        check("hold_addr", SDRAM_ADDRESS, prev_adr);
      end
      if (prev_afull) check("afull_new_read", SDRAM_READ & ~prev_read, 0);
    end
    if (afull_after > 0 && !afull_done && (wr_cnt - wr_base) >= afull_after) begin
      FIFO_AFULL = 1'b1;
      afull_t    = cyc;
      afull_done = 1'b1;
    end else if (FIFO_AFULL && (cyc - afull_t) >= 30) begin
      FIFO_AFULL = 1'b0;
    end
    w = stall_all || (acc_cnt >= stall_at) || (wpct > 0 && $urandom_range(99) < wpct);
    SDRAM_WAITREQUEST = w;
    if (SDRAM_READ && !w) begin
      acc_cnt++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      if (exp_adr.size() == 0) check("unexpected_read", SDRAM_READ, 0);
      else check("read_addr", SDRAM_ADDRESS, exp_adr.pop_front());
      pend.push_back('{cyc + lat, SDRAM_ADDRESS});
    end
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      SDRAM_READDATAVALID = 1'b1;
      SDRAM_READDATA      = data_of(pend[0].a);
      void'(pend.pop_front());
    end else begin
      SDRAM_READDATAVALID = 1'b0;
      SDRAM_READDATA      = '0;
    end
    prev_read  = SDRAM_READ;
    prev_stall = SDRAM_READ && w;
    prev_afull = FIFO_AFULL;
    prev_adr   = SDRAM_ADDRESS;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse(input logic [27:0] a, input logic [27:0] s);
    @(negedge CLK);
    START_ADR = a; BUF_SIZE = s; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_done(input logic [15:0] target, input int budget);
    int n = 0;
    while (DONE_CNT !== target && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("done_cnt", DONE_CNT, target);
  endtask

  initial begin
    vec_t vecs[4];
    int acc0, wr0, n;

    vecs[0] = '{28'h0000100,  4, 3,  0, 0,  3, 16'd1};
    vecs[1] = '{28'h0001000, 16, 3, 50, 0, -1, 16'd2};
    vecs[2] = '{28'h0002000, 32, 20, 0, 0, -1, 16'd3};
    vecs[3] = '{28'h0003000, 12, 4,  0, 5, -1, 16'd4};

    tick(3);
    check("rst_read", SDRAM_READ, 0);
    check("rst_fifo_wr", FIFO_WR, 0);
    check("rst_done", DONE_CNT, 0);
    check("rst_busy", BUSY, 0);
    check("rst_cmd_empty", CMD_FIFO_EMPTY, 1);
    check("rst_cmd_aempty", CMD_FIFO_AEMPTY, 1);
    SRST = 1'b0;
    tick(2);

    for (int i = 0; i < 4; i++) begin
      lat = vecs[i].lat; wpct = vecs[i].wpct;
      acc0 = acc_cnt; wr0 = wr_cnt; wr_base = wr_cnt;
      first_acc = -1; max_pend = 0; afull_wr = 0; afull_done = 0;
      afull_after = vecs[i].afull_after;
      for (int k = 0; k < int'(vecs[i].size); k++) begin
        exp_adr.push_back(vecs[i].adr + 28'(k));
        exp_wr.push_back(vecs[i].adr + 28'(k));
      end
      pulse(vecs[i].adr, vecs[i].size);
      wait_done(vecs[i].exp_done, 3000);
      tick(5);
      check("vec_accepts", acc_cnt - acc0, vecs[i].size);
      check("vec_writes", wr_cnt - wr0, vecs[i].size);
      check("vec_busy_after", BUSY, 0);
      check("vec_max_outst_le8", max_pend <= MAXO, 1);
      if (vecs[i].span >= 0) check("vec_consecutive", last_acc - first_acc, vecs[i].span);
      if (vecs[i].afull_after > 0) check("afull_inflight_written", afull_wr > 0, 1);
      afull_after = 0; wpct = 0;
    end

    // Queue of three with address wrap and a zero-length buffer.
    lat = 3; acc0 = acc_cnt; wr0 = wr_cnt;
    exp_adr.push_back(28'hFFFFFFE); exp_adr.push_back(28'hFFFFFFF);
    exp_adr.push_back(28'h0000000); exp_adr.push_back(28'h0000001);
    exp_adr.push_back(28'h0000300); exp_adr.push_back(28'h0000301);
    foreach (exp_adr[k]) exp_wr.push_back(exp_adr[k]);
    pulse(28'h0FFFFFFE, 4);
    pulse(28'h0000200, 0);
    pulse(28'h0000300, 2);
    wait_done(16'd7, 1000);
    tick(5);
    check("queue_accepts", acc_cnt - acc0, 6);
    check("queue_writes", wr_cnt - wr0, 6);

    // Fill the command FIFO while the engine is stalled; the 9th push drops.
    stall_all = 1'b1;
    exp_adr.push_back(28'h0000400); exp_wr.push_back(28'h0000400);
    pulse(28'h0000400, 1);
    n = 0;
    while (!(BUSY && SDRAM_READ) && n < 50) begin @(negedge CLK); n++; end
    check("stall_read_up", SDRAM_READ, 1);
    pulse(28'h0000500, 0);
    check("one_entry_empty", CMD_FIFO_EMPTY, 0);
    check("one_entry_aempty", CMD_FIFO_AEMPTY, 1);
    for (int k = 1; k < 9; k++) pulse(28'h0000500 + 28'(k), 0);
    check("full_empty", CMD_FIFO_EMPTY, 0);
    check("full_aempty", CMD_FIFO_AEMPTY, 0);
    stall_all = 1'b0;
    wait_done(16'd16, 1000);
    tick(30);
    check("drop_done", DONE_CNT, 16);
    check("drop_cmd_empty", CMD_FIFO_EMPTY, 1);
    check("drop_busy", BUSY, 0);

    // Reset with five reads outstanding; their late returns must be ignored.
    lat = 30; acc0 = acc_cnt; stall_at = acc_cnt + 5;
    for (int k = 0; k < 8; k++) begin
      exp_adr.push_back(28'h0000600 + 28'(k));
      exp_wr.push_back(28'h0000600 + 28'(k));
    end
    pulse(28'h0000600, 8);
    n = 0;
    while (acc_cnt < stall_at && n < 100) begin @(negedge CLK); n++; end
    check("rst_outstanding", acc_cnt - acc0, 5);
    tick(2);
    lim_chk_en = 1'b0;
    @(negedge CLK);
    SRST = 1'b1;
    exp_adr.delete();
    exp_wr.delete();
    tick(2);
    SRST = 1'b0;
    stall_at = 1 << 30;
    check("mid_rst_read", SDRAM_READ, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_done", DONE_CNT, 0);
    check("mid_rst_fifo_wr", FIFO_WR, 0);
    wr0 = wr_cnt;
    tick(50);
    check("stale_writes", wr_cnt - wr0, 0);
    check("post_rst_read", SDRAM_READ, 0);
    check("post_rst_done", DONE_CNT, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simple_dma_rd.md
# simple_dma_rd

Read-direction companion to the SDRAM write DMA. Accepts buffer descriptors (start address, size in 128-bit words) through a small command FIFO, issues pipelined Avalon-MM reads to SDRAM, and pushes the returned words into a downstream data FIFO for the consumer. Each completed buffer increments a done counter. The block sits between the SDRAM controller read port and the playback/readout data path.

## Interface
- ADR_W, 28, SDRAM word address width; also the BUF_SIZE width.
- DATA_W, 128, SDRAM data width.
- MAX_OUTST, 8, maximum number of accepted reads whose data has not yet returned.
- CMD_DEPTH, 3, command FIFO depth, 2**CMD_DEPTH entries.
- CLK  in  1  clock; reset SRST, synchronous, active-high.
- SRST  in  1  synchronous reset, active-high.
- START_ADR  in  ADR_W  buffer start address, in 16-byte words.
- BUF_SIZE  in  ADR_W  buffer length, in 16-byte words.
- START  in  1  rising edge enqueues {BUF_SIZE, START_ADR}.
- DONE_CNT  out  16  count of completed buffers; wraps at 2^16.
- BUSY  out  1  descriptor in progress.
- CMD_FIFO_EMPTY  out  1  command FIFO empty.
- CMD_FIFO_AEMPTY  out  1  command FIFO almost empty.
- FIFO_DATA  out  DATA_W  data to the downstream FIFO.
- FIFO_WR  out  1  write strobe to the downstream FIFO.
- FIFO_AFULL  in  1  downstream almost-full; offset must be >= MAX_OUTST+1.
- SDRAM_ADDRESS  out  ADR_W  read address.
- SDRAM_READ  out  1  read request.
- SDRAM_WAITREQUEST  in  1  request stall.
- SDRAM_READDATA  in  DATA_W  read data.
- SDRAM_READDATAVALID  in  1  read data valid.

## Operation
- START edge detector uses a registered START. Every 0→1 transition writes one descriptor. A write while the command FIFO is full is silently dropped.
- FSM states and transitions:
  - IDLE: if the command FIFO is not empty, pulse the read strobe and go to FETCH.
  - FETCH: wait one cycle for FIFO DOUT to become valid; go to LOAD.
  - LOAD: capture address and size. If size==0, increment DONE_CNT and return to IDLE; otherwise go to ISSUE.
  - ISSUE: issue reads until the remaining count reaches 0, then go to DRAIN.
  - DRAIN: wait until the outstanding count is 0, increment DONE_CNT, go to IDLE.
- Read acceptance = SDRAM_READ & ~SDRAM_WAITREQUEST. Each acceptance increments the address by 1 (mod 2^ADR_W, so it wraps to 0), decrements the remaining count, and increments the outstanding count.
- A new request may be raised only when all three hold:
  - remaining count != 0;
  - outstanding count plus in-flight request is below MAX_OUTST;
  - FIFO_AFULL is 0.
- Once SDRAM_READ is high, it and SDRAM_ADDRESS hold stable until accepted, regardless of FIFO_AFULL.
- Outstanding counter is $clog2(MAX_OUTST+1) bits:
  - increments on acceptance;
  - decrements on SDRAM_READDATAVALID;
  - simultaneous acceptance and return leave it unchanged.
- Returned data: FIFO_DATA/FIFO_WR are registered copies of SDRAM_READDATA/SDRAM_READDATAVALID. A SDRAM_READDATAVALID arriving while the outstanding count is 0 (a stale return after reset) is discarded; FIFO_WR stays 0.
- BUSY = state != IDLE.

## Timing
- Reset values:
  - SDRAM_READ=0, FIFO_WR=0, DONE_CNT=0, BUSY=0, state=IDLE.
  - Outstanding and remaining counts = 0; command FIFO flushed.
  - SDRAM_ADDRESS and FIFO_DATA are don't-care.
- SRST mid-transfer aborts immediately. No DONE_CNT increment for the aborted buffer.
- Command FIFO not empty at cycle t in IDLE → DOUT_RD at t+1 → LOAD at t+3 → first SDRAM_READ at t+4.
- Returned data reaches FIFO_WR one cycle after SDRAM_READDATAVALID.
- DONE_CNT increments in the cycle after the last data return has been counted.
- Back-to-back descriptors: at least 4 idle cycles between the last return of one buffer and the first read of the next.
- Peak throughput is 1 read per cycle with WAITREQUEST=0 and read latency <= MAX_OUTST.

## Structure
- Shared DMA package holds:
  - ADR_W and DATA_W defaults;
  - the FSM state encoding (IDLE, FETCH, LOAD, ISSUE, DRAIN);
  - the descriptor layout {size, addr}, size in the upper ADR_W bits. This layout is common to the write DMA.
- The command FIFO is an instance of the existing fifo_bram_sync:
  - DATA_WIDTH=2*ADR_W, DEPTH=CMD_DEPTH, AFULL_OFFSET=2, AEMPTY_OFFSET=2.
- No other sub-modules.

## Test plan
- Single buffer: addr=0x100, size=4, WAITREQUEST=0, latency 3. Expect 4 reads at 0x100..0x103 on consecutive cycles, 4 FIFO_WR with the matching data in order, DONE_CNT=1, BUSY low afterwards.
- Backpressure: WAITREQUEST random 50%, size=16. Expect SDRAM_ADDRESS stable while stalled, exactly 16 acceptances, no address skipped or repeated.
- Outstanding limit: latency 20, size=32. Expect the outstanding count never to exceed 8 and SDRAM_READ low while at 8; all 32 words delivered.
- Downstream full: hold FIFO_AFULL=1 after 5 words. Expect no new SDRAM_READ raised, in-flight data still written, resume on release; total 12 of size=12.
- Queue and edge cases:
  - 3 START pulses: (0x0FFFFFFE, 4), (0x200, 0), (0x300, 2). Expect addresses to wrap to 0x0000000/0x0000001, the size-0 buffer to count without reads, DONE_CNT=3.
  - 9th START while the FIFO is full is dropped.
- Reset mid-transfer: assert SRST with 5 reads outstanding and deliver their READDATAVALID after reset. Expect FIFO_WR=0 for all, DONE_CNT=0, SDRAM_READ=0.
